// File: rtl/mem_byte_sequencer_pkg.sv
// Shared definitions for the MEM-stage byte sequencer: size select codes,
// FSM state encoding, read-pipe tag payload and size/extension helpers.
package mem_byte_sequencer_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LANE_W = 3;

    localparam logic [SEL_W-1:0] MEM_BYTE   = 2'b00;
    localparam logic [SEL_W-1:0] MEM_HALF   = 2'b01;
    localparam logic [SEL_W-1:0] MEM_WORD   = 2'b10;
    localparam logic [SEL_W-1:0] MEM_DOUBLE = 2'b11;

    localparam logic [7:0]  ZERO_BYTE = 8'h00;
    localparam logic [63:0] ZERO_WORD = 64'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Tag travelling alongside an issued read address.
    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
    } rd_tag_t;

    // Byte count for a size select; DOUBLE collapses to WORD on 32-bit builds.
    function automatic logic [CNT_W-1:0] sel_bytes(input logic [SEL_W-1:0] sel, input logic dbl_ok);
        logic [CNT_W-1:0] n;
        case (sel)
            MEM_BYTE:   n = 4'd1;
            MEM_HALF:   n = 4'd2;
            MEM_WORD:   n = 4'd4;
            MEM_DOUBLE: n = dbl_ok ? 4'd8 : 4'd4;
            default:    n = 4'd4;
        endcase
        return n;
    endfunction

    // Sign/zero extension from bit 8n-1 to 64 bits.
    function automatic logic [63:0] extend64(input logic [63:0] v, input logic [CNT_W-1:0] n, input logic s);
        logic [63:0] r;
        case (n)
            4'd1:    r = {{56{s & v[7]}},  v[7:0]};
            4'd2:    r = {{48{s & v[15]}}, v[15:0]};
            4'd4:    r = {{32{s & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// Request/response bundle between the MEM stage (master) and the sequencer (slave).
//  flush, req_valid/we/sel/sign/addr/wdata : master -> slave
//  req_ready, resp_valid/rdata/fault       : slave -> master
interface mem_byte_sequencer_if
    import mem_byte_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
);
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [SEL_W-1:0]  req_sel;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_fault;

    modport master (
        output flush, req_valid, req_we, req_sel, req_sign, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  flush, req_valid, req_we, req_sel, req_sign, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/mem_byte_sequencer_rd_pipe.sv
// mem_rd_pipe: READ_LAT-deep shift register of {valid, lane} tags. A tag
// enters together with its registered address and leaves in the cycle its
// read byte is on mem_rbyte_i.
//  clk, rst (sync, active-low), clr (drop all in-flight tags), tag_i, tag_o
module mem_rd_pipe
    import mem_byte_sequencer_pkg::*;
#(
    parameter int unsigned READ_LAT = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);
    rd_tag_t stage_q [READ_LAT];
    rd_tag_t stage_d [READ_LAT];

    always_comb begin
        for (int i = 0; i < READ_LAT; i++) stage_d[i] = stage_q[i];
        if (clr) begin
            for (int i = 0; i < READ_LAT; i++) stage_d[i] = '0;
        end else begin
            stage_d[0] = tag_i;
            for (int i = 1; i < READ_LAT; i++) stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < READ_LAT; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < READ_LAT; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign tag_o = stage_q[READ_LAT-1];
endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: serialises B/H/W/D loads and stores onto a byte-wide
// RAM port, one byte per cycle, with a one-cycle response pulse.
//  clk, rst           : clock, synchronous active-low reset
//  bus (slave)        : flush, req_* handshake, resp_* completion
//  mem_addr_o/we_o/wbyte_o : byte RAM request (all 0 when idle)
//  mem_rbyte_i        : read byte, valid READ_LAT cycles after its address
// Optional: MEM_ALIGN_CHECK_EN enables misalignment/size faulting.
module mem_byte_sequencer
    import mem_byte_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned READ_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_byte_sequencer_if.slave bus,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_we_o,
    output logic [7:0]         mem_wbyte_o,
    input  logic [7:0]         mem_rbyte_i
);
    localparam logic DBL_OK = (XLEN == 32'd64);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              sign_q, sign_d, done_q, done_d;
    logic [63:0]       lanes_q, lanes_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wbyte_q, mem_wbyte_d;
    logic              resp_valid_q, resp_valid_d, resp_fault_q, resp_fault_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;

    logic              req_ready_c, flush_c, misalign;
    logic [CNT_W-1:0]  req_n;
    logic [7:0]        wbyte_k;
    logic [ADDR_W-1:0] next_addr;
    rd_tag_t           tag_in, tag_out;

    assign req_ready_c = rst && (state_q == ST_IDLE) && !bus.flush;
    assign flush_c     = bus.flush && (state_q != ST_IDLE);

    mem_rd_pipe #(.READ_LAT(READ_LAT)) u_rd_pipe (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_c),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        sign_d       = sign_q;
        lanes_d      = lanes_q;
        done_d       = done_q;
        mem_addr_d   = '0;
        mem_we_d     = 1'b0;
        mem_wbyte_d  = ZERO_BYTE;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_fault_d = 1'b0;
        tag_in       = '0;

        req_n     = sel_bytes(bus.req_sel, DBL_OK);
        wbyte_k   = 8'(wdata_q >> {cnt_q, 3'b000});
        next_addr = base_q + ADDR_W'(cnt_q);
        misalign  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        case (bus.req_sel)
            MEM_HALF:   misalign = bus.req_addr[0];
            MEM_WORD:   misalign = |bus.req_addr[1:0];
            MEM_DOUBLE: misalign = (|bus.req_addr[2:0]) || !DBL_OK;
            default:    misalign = 1'b0;
        endcase
`endif

        // Returning read byte lands in its lane; last lane arms the response.
        if (tag_out.valid) begin
            lanes_d[{tag_out.lane, 3'b000} +: 8] = mem_rbyte_i;
            if ({1'b0, tag_out.lane} == n_q - CNT_W'(1)) done_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_c) begin
                    if (misalign) begin
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        n_d        = req_n;
                        base_d     = bus.req_addr;
                        wdata_d    = bus.req_wdata;
                        sign_d     = bus.req_sign;
                        cnt_d      = CNT_W'(1);
                        lanes_d    = ZERO_WORD;
                        done_d     = 1'b0;
                        mem_addr_d = bus.req_addr;
                        if (bus.req_we) begin
                            mem_we_d    = 1'b1;
                            mem_wbyte_d = bus.req_wdata[7:0];
                            state_d     = ST_WRITE;
                        end else begin
                            tag_in  = '{valid: 1'b1, lane: '0};
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_q == n_q) begin
                    resp_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = next_addr;
                    mem_wbyte_d = wbyte_k;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                if (cnt_q == n_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    mem_addr_d = next_addr;
                    tag_in     = '{valid: 1'b1, lane: cnt_q[LANE_W-1:0]};
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (done_q) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = XLEN'(extend64(lanes_q, n_q, sign_q));
                    done_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Squash: abandon the access, nothing reaches the RAM or the response.
        if (flush_c) begin
            state_d      = ST_IDLE;
            done_d       = 1'b0;
            mem_addr_d   = '0;
            mem_we_d     = 1'b0;
            mem_wbyte_d  = ZERO_BYTE;
            resp_valid_d = 1'b0;
            resp_rdata_d = '0;
            resp_fault_d = 1'b0;
            tag_in       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            sign_q       <= 1'b0;
            lanes_q      <= '0;
            done_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wbyte_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            sign_q       <= sign_d;
            lanes_q      <= lanes_d;
            done_q       <= done_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wbyte_q  <= mem_wbyte_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_we_o       = mem_we_q;
    assign mem_wbyte_o    = mem_wbyte_q;
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer: a 32-bit instance for most scenarios
// and a 64-bit instance for DOUBLE loads; both see the same byte RAM model.
module tb_mem_byte_sequencer;
    import mem_byte_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] a32, a64;
    logic        we32, we64;
    logic [7:0]  wb32, wb64, rb32, rb64;
    logic [7:0]  mem [4096];

    mem_byte_sequencer_if #(.ADDR_W(32), .XLEN(32)) b32 ();
    mem_byte_sequencer_if #(.ADDR_W(32), .XLEN(64)) b64 ();

    mem_byte_sequencer #(.ADDR_W(32), .XLEN(32), .READ_LAT(2)) dut32 (
        .clk(clk), .rst(rst), .bus(b32),
        .mem_addr_o(a32), .mem_we_o(we32), .mem_wbyte_o(wb32), .mem_rbyte_i(rb32)
    );
    mem_byte_sequencer #(.ADDR_W(32), .XLEN(64), .READ_LAT(2)) dut64 (
        .clk(clk), .rst(rst), .bus(b64),
        .mem_addr_o(a64), .mem_we_o(we64), .mem_wbyte_o(wb64), .mem_rbyte_i(rb64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with READ_LAT=2: byte for the address shown in cycle c is on the bus in cycle c+1.
    always @(posedge clk) begin
        rb32 <= mem[a32[11:0]];
        rb64 <= mem[a64[11:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic we, input logic [1:0] sel, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wd);
        b32.req_we = we; b32.req_sel = sel; b32.req_sign = sign;
        b32.req_addr = addr; b32.req_wdata = wd; b32.req_valid = 1'b1;
        #1;
        checks++; if (b32.req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %b want 1", b32.req_ready); end
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a32 !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", a32); end
        checks++; if ({we32, b32.resp_valid, b32.resp_fault} !== 3'b000) begin errors++; $display("FAIL rst_ctl: got %b want 000", {we32, b32.resp_valid, b32.resp_fault}); end
        checks++; if (b32.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", b32.resp_rdata); end
        checks++; if ({a64, we64, wb64} !== 41'h0) begin errors++; $display("FAIL rst_mem64: got %h want 0", {a64, we64, wb64}); end
        rst = 1'b1;
        #1;
        checks++; if (b32.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", b32.req_ready); end
        step();
    endtask

    task automatic test_store_word();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        issue32(1'b1, MEM_WORD, 1'b0, 32'h100, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            checks++; if ({we32, a32, wb32} !== {1'b1, 32'h100 + 32'(k), exp_b[k]}) begin errors++; $display("FAIL sw_cycle%0d: got we=%b a=%h b=%h want we=1 a=%h b=%h", k + 1, we32, a32, wb32, 32'h100 + 32'(k), exp_b[k]); end
            checks++; if (b32.resp_valid !== 1'b0) begin errors++; $display("FAIL sw_early_resp%0d: got %b want 0", k + 1, b32.resp_valid); end
            step();
        end
        checks++; if ({b32.resp_valid, we32, a32, b32.resp_rdata} !== {2'b10, 32'h0, 32'h0}) begin errors++; $display("FAIL sw_resp: got v=%b we=%b a=%h d=%h want v=1 we=0 a=0 d=0", b32.resp_valid, we32, a32, b32.resp_rdata); end
        checks++; if (b32.req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b want 1", b32.req_ready); end
        step();
        checks++; if (b32.resp_valid !== 1'b0) begin errors++; $display("FAIL sw_pulse: got %b want 0", b32.resp_valid); end
    endtask

    task automatic test_load_byte();
        issue32(1'b0, MEM_BYTE, 1'b1, 32'h20, 32'h0);
        checks++; if ({we32, a32} !== {1'b0, 32'h20}) begin errors++; $display("FAIL lb_addr: got we=%b a=%h want we=0 a=20", we32, a32); end
        step();
        checks++; if (a32 !== 32'h0) begin errors++; $display("FAIL lb_addr_idle: got %h want 0", a32); end
        step();
        checks++; if (b32.resp_valid !== 1'b0) begin errors++; $display("FAIL lb_early: got %b want 0", b32.resp_valid); end
        step();
        checks++; if ({b32.resp_valid, b32.resp_rdata} !== {1'b1, 32'hFFFFFF80}) begin errors++; $display("FAIL lb_signed: got v=%b d=%h want v=1 d=ffffff80", b32.resp_valid, b32.resp_rdata); end
        issue32(1'b0, MEM_BYTE, 1'b0, 32'h20, 32'h0);
        step(); step(); step();
        checks++; if ({b32.resp_valid, b32.resp_rdata} !== {1'b1, 32'h00000080}) begin errors++; $display("FAIL lb_unsigned: got v=%b d=%h want v=1 d=00000080", b32.resp_valid, b32.resp_rdata); end
        issue32(1'b0, MEM_HALF, 1'b1, 32'h30, 32'h0);
        step(); step(); step(); step();
        checks++; if ({b32.resp_valid, b32.resp_rdata} !== {1'b1, 32'hFFFF9000}) begin errors++; $display("FAIL lh_signed: got v=%b d=%h want v=1 d=ffff9000", b32.resp_valid, b32.resp_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        issue32(1'b0, MEM_HALF, 1'b1, 32'h102, 32'h0);
        checks++; if (a32 !== 32'h102) begin errors++; $display("FAIL lh_a0: got %h want 102", a32); end
        step();
        checks++; if (a32 !== 32'h103) begin errors++; $display("FAIL lh_a1: got %h want 103", a32); end
        step(); step();
        checks++; if (b32.resp_valid !== 1'b0) begin errors++; $display("FAIL lh_early: got %b want 0", b32.resp_valid); end
        step();
        checks++; if ({b32.resp_valid, b32.resp_rdata, b32.resp_fault} !== {1'b1, 32'h00001234, 1'b0}) begin errors++; $display("FAIL lh_resp: got v=%b d=%h f=%b want v=1 d=00001234 f=0", b32.resp_valid, b32.resp_rdata, b32.resp_fault); end
        issue32(1'b1, MEM_BYTE, 1'b0, 32'h40, 32'h0000005A);
        checks++; if ({we32, a32, wb32} !== {1'b1, 32'h40, 8'h5A}) begin errors++; $display("FAIL b2b_store: got we=%b a=%h b=%h want we=1 a=40 b=5a", we32, a32, wb32); end
        step();
        checks++; if ({b32.resp_valid, b32.resp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL b2b_resp: got v=%b d=%h want v=1 d=0", b32.resp_valid, b32.resp_rdata); end
        step();
    endtask

    task automatic test_flush();
        int seen;
        issue32(1'b0, MEM_WORD, 1'b0, 32'h200, 32'h0);
        step();
        checks++; if (a32 !== 32'h201) begin errors++; $display("FAIL fl_a1: got %h want 201", a32); end
        b32.flush = 1'b1;
        step();
        b32.flush = 1'b0;
        #1;
        checks++; if ({a32, we32} !== 33'h0) begin errors++; $display("FAIL fl_addr: got %h want 0", a32); end
        checks++; if (b32.req_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b want 1", b32.req_ready); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (b32.resp_valid === 1'b1) seen++;
            step();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL fl_no_resp: got %0d responses want 0", seen); end
        // flush wins over a simultaneous request
        b32.req_we = 1'b1; b32.req_sel = MEM_BYTE; b32.req_addr = 32'h60; b32.req_wdata = 32'h11;
        b32.req_valid = 1'b1; b32.flush = 1'b1;
        #1;
        checks++; if (b32.req_ready !== 1'b0) begin errors++; $display("FAIL fl_ready_low: got %b want 0", b32.req_ready); end
        step();
        b32.req_valid = 1'b0; b32.flush = 1'b0;
        checks++; if ({we32, a32} !== 33'h0) begin errors++; $display("FAIL fl_beats_req: got we=%b a=%h want 0", we32, a32); end
        // flush in the response cycle still delivers
        issue32(1'b1, MEM_BYTE, 1'b0, 32'h50, 32'h77);
        step();
        b32.flush = 1'b1;
        #1;
        checks++; if (b32.resp_valid !== 1'b1) begin errors++; $display("FAIL fl_resp_kept: got %b want 1", b32.resp_valid); end
        step();
        b32.flush = 1'b0;
        checks++; if (b32.resp_valid !== 1'b0) begin errors++; $display("FAIL fl_resp_pulse: got %b want 0", b32.resp_valid); end
    endtask

    task automatic test_reset_mid();
        issue32(1'b1, MEM_WORD, 1'b0, 32'h300, 32'h11223344);
        checks++; if ({we32, wb32} !== {1'b1, 8'h44}) begin errors++; $display("FAIL rm_first: got we=%b b=%h want we=1 b=44", we32, wb32); end
        step();
        rst = 1'b0;
        step();
        checks++; if ({we32, a32, wb32, b32.resp_valid, b32.req_ready} !== 43'h0) begin errors++; $display("FAIL rm_outputs: got we=%b a=%h b=%h v=%b r=%b want all 0", we32, a32, wb32, b32.resp_valid, b32.req_ready); end
        rst = 1'b1;
        step();
        checks++; if ({b32.req_ready, b32.resp_valid, we32} !== 3'b100) begin errors++; $display("FAIL rm_recover: got r/v/we=%b want 100", {b32.req_ready, b32.resp_valid, we32}); end
    endtask

    task automatic test_double();
        b64.req_we = 1'b0; b64.req_sel = MEM_DOUBLE; b64.req_sign = 1'b1;
        b64.req_addr = 32'h8; b64.req_wdata = 64'h0; b64.req_valid = 1'b1;
        #1;
        checks++; if (b64.req_ready !== 1'b1) begin errors++; $display("FAIL ld64_ready: got %b want 1", b64.req_ready); end
        step();
        b64.req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if ({we64, a64, wb64} !== {1'b0, 32'h8 + 32'(k), 8'h00}) begin errors++; $display("FAIL ld64_a%0d: got we=%b a=%h b=%h want we=0 a=%h", k, we64, a64, wb64, 32'h8 + 32'(k)); end
            step();
        end
        step();
        checks++; if (b64.resp_valid !== 1'b0) begin errors++; $display("FAIL ld64_early: got %b want 0", b64.resp_valid); end
        step();
        checks++; if ({b64.resp_valid, b64.resp_rdata} !== {1'b1, 64'h0807060504030201}) begin errors++; $display("FAIL ld64_resp: got v=%b d=%h want v=1 d=0807060504030201", b64.resp_valid, b64.resp_rdata); end
        step();
        // DOUBLE on the 32-bit instance
        issue32(1'b0, MEM_DOUBLE, 1'b0, 32'h8, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if ({b32.resp_valid, b32.resp_fault, a32, b32.resp_rdata} !== {2'b11, 64'h0}) begin errors++; $display("FAIL ld32_fault: got v=%b f=%b a=%h d=%h want v=1 f=1 a=0 d=0", b32.resp_valid, b32.resp_fault, a32, b32.resp_rdata); end
        step();
`else
        for (int k = 0; k < 4; k++) begin
            checks++; if (a32 !== 32'h8 + 32'(k)) begin errors++; $display("FAIL ld32_a%0d: got %h want %h", k, a32, 32'h8 + 32'(k)); end
            step();
        end
        checks++; if (a32 !== 32'h0) begin errors++; $display("FAIL ld32_stop: got %h want 0", a32); end
        step(); step();
        checks++; if ({b32.resp_valid, b32.resp_rdata, b32.resp_fault} !== {1'b1, 32'h04030201, 1'b0}) begin errors++; $display("FAIL ld32_resp: got v=%b d=%h f=%b want v=1 d=04030201 f=0", b32.resp_valid, b32.resp_rdata, b32.resp_fault); end
        step();
`endif
    endtask

    task automatic test_align();
        issue32(1'b0, MEM_WORD, 1'b0, 32'h102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        checks++; if ({b32.resp_valid, b32.resp_fault, a32, b32.resp_rdata} !== {2'b11, 64'h0}) begin errors++; $display("FAIL lw_mis_fault: got v=%b f=%b a=%h d=%h want v=1 f=1 a=0 d=0", b32.resp_valid, b32.resp_fault, a32, b32.resp_rdata); end
        step();
        checks++; if ({b32.resp_valid, b32.resp_fault, a32} !== 34'h0) begin errors++; $display("FAIL lw_mis_after: got v=%b f=%b a=%h want 0", b32.resp_valid, b32.resp_fault, a32); end
        issue32(1'b1, MEM_HALF, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF);
        checks++; if ({b32.resp_valid, b32.resp_fault, we32} !== 3'b110) begin errors++; $display("FAIL sh_mis_fault: got v/f/we=%b want 110", {b32.resp_valid, b32.resp_fault, we32}); end
        step();
`else
        for (int k = 0; k < 4; k++) begin
            checks++; if (a32 !== 32'h102 + 32'(k)) begin errors++; $display("FAIL lw_mis_a%0d: got %h want %h", k, a32, 32'h102 + 32'(k)); end
            step();
        end
        step(); step();
        checks++; if ({b32.resp_valid, b32.resp_rdata, b32.resp_fault} !== {1'b1, 32'hCDAB1234, 1'b0}) begin errors++; $display("FAIL lw_mis_resp: got v=%b d=%h f=%b want v=1 d=cdab1234 f=0", b32.resp_valid, b32.resp_rdata, b32.resp_fault); end
        // address wrap across the top of the space
        issue32(1'b1, MEM_HALF, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF);
        checks++; if ({we32, a32, wb32} !== {1'b1, 32'hFFFFFFFF, 8'hEF}) begin errors++; $display("FAIL wrap_a0: got we=%b a=%h b=%h want we=1 a=ffffffff b=ef", we32, a32, wb32); end
        step();
        checks++; if ({we32, a32, wb32} !== {1'b1, 32'h0, 8'hBE}) begin errors++; $display("FAIL wrap_a1: got we=%b a=%h b=%h want we=1 a=0 b=be", we32, a32, wb32); end
        step();
        checks++; if ({b32.resp_valid, b32.resp_fault, we32} !== 3'b100) begin errors++; $display("FAIL wrap_resp: got v/f/we=%b want 100", {b32.resp_valid, b32.resp_fault, we32}); end
        step();
`endif
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h020] = 8'h80;
        mem[12'h030] = 8'h00; mem[12'h031] = 8'h90;
        mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
        mem[12'h104] = 8'hAB; mem[12'h105] = 8'hCD;
        for (int i = 0; i < 8; i++) mem[8 + i] = 8'(i + 1);

        b32.flush = 1'b0; b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_sel = MEM_BYTE;
        b32.req_sign = 1'b0; b32.req_addr = '0; b32.req_wdata = '0;
        b64.flush = 1'b0; b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_sel = MEM_BYTE;
        b64.req_sign = 1'b0; b64.req_addr = '0; b64.req_wdata = '0;

        test_reset();
        test_store_word();
        test_load_byte();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_double();
        test_align();

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
